toggle_event_rx: RTL and testbench

//   Receive end of the toggle-event link. The transmitter is a T flip-flop whose output

---
 rtl/toggle_link_pkg.sv | 5 +
 rtl/toggle_event_rx_sync_chain.sv | 18 +
 rtl/toggle_event_rx.sv | 78 +++++++
 tb/tb_toggle_event_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_link_pkg.sv
// Constants shared by both ends of the toggle-event link.
package toggle_link_pkg;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam logic TOG_IDLE        = 1'b0;
endpackage

// File: rtl/toggle_event_rx_sync_chain.sv
// Plain flop chain for bringing the toggle line into the clk domain; resets to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) sr <= '0;
    else      sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-link receiver: recovers one pulse per line change, counts events and
// queues unconsumed events behind a valid/ready port.
module toggle_event_rx
  import toggle_link_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = 8,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tog_in,
  input  logic              clr_cnt,
  input  logic              evt_ready,
  output logic              evt_pulse,
  output logic              evt_valid,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overflow
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              sync_last;
  logic              ref_q;
  logic              pop;
  logic              ovf_set;
  logic [PEND_W-1:0] pend_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (tog_in),
    .q   (sync_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q     <= TOG_IDLE;
      evt_pulse <= 1'b0;
    end else begin
      ref_q     <= sync_last;
      evt_pulse <= sync_last ^ ref_q;
    end
  end

  assign pop = evt_valid & evt_ready;

  // A pulse coinciding with a pop leaves pending alone, even when full.
  always_comb begin
    pend_nxt = pending;
    ovf_set  = 1'b0;
    if (evt_pulse && !pop) begin
      if (pending == PEND_MAX) ovf_set  = 1'b1;
      else                     pend_nxt = pending + 1'b1;
    end else if (!evt_pulse && pop) begin
      pend_nxt = pending - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending   <= '0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      pending   <= pend_nxt;
      evt_valid <= (pend_nxt != '0);
      overflow  <= overflow | ovf_set;
    end
  end

  // Clear wins over a same-cycle pulse; dropped events are still counted.
  always_ff @(posedge clk) begin
    if (!rst)           evt_count <= '0;
    else if (clr_cnt)   evt_count <= '0;
    else if (evt_pulse) evt_count <= evt_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: directed table, hand sequences, then random traffic
// against a history-based reference model.
module tb_toggle_event_rx;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tog_in = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_pulse;
  logic       evt_valid;
  logic [2:0] pending;
  logic [7:0] evt_count;
  logic       overflow;

  toggle_event_rx #(.SYNC_STAGES(S), .CNT_W(8), .PEND_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .clr_cnt   (clr_cnt),
    .evt_ready (evt_ready),
    .evt_pulse (evt_pulse),
    .evt_valid (evt_valid),
    .pending   (pending),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int ntot = 0;
  int npass = 0;
  int npulse = 0;
  bit chk_model = 0;

  // Reference model: line history plus plain integer bookkeeping.
  bit tq[$];
  int m_pulse = 0, m_pend = 0, m_cnt = 0, m_ovf = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge();
    int op;
    bit pop;
    if (!rst) begin
      tq = {};
      repeat (S + 2) tq.push_back(1'b0);
      m_pulse = 0; m_pend = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      op  = m_pulse;
      pop = (m_pend != 0) && evt_ready;
      tq.push_front(tog_in);
      void'(tq.pop_back());
      // line value sampled S edges ago differs from the one before it
      m_pulse = (tq[S] != tq[S+1]) ? 1 : 0;
      if (op != 0 && !pop) begin
        if (m_pend == 7) m_ovf = 1;
        else             m_pend = m_pend + 1;
      end else if (op == 0 && pop) begin
        m_pend = m_pend - 1;
      end
      m_cnt = clr_cnt ? 0 : (m_cnt + op) % 256;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (evt_pulse) npulse++;
    if (chk_model) begin
      chk("rnd_pulse", int'(evt_pulse), m_pulse);
      chk("rnd_pending", int'(pending), m_pend);
      chk("rnd_valid", int'(evt_valid), (m_pend != 0) ? 1 : 0);
      chk("rnd_count", int'(evt_count), m_cnt);
      chk("rnd_overflow", int'(overflow), m_ovf);
    end
  endtask

  task automatic toggles(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tog_in = ~tog_in;
      repeat (gap) step();
    end
  endtask

  task automatic wait_pulse();
    bit got;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (evt_pulse) got = 1;
    end
    chk("pulse_seen", int'(got), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0; clr_cnt = 1'b0; evt_ready = 1'b0; tog_in = 1'b0;
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    bit r, t, c, rd;
    int p, pe, cn, o;
  } vec_t;
  vec_t vecs[$];

  function automatic void addv(bit r, bit t, bit c, bit rd, int p, int pe, int cn, int o);
    vec_t v;
    v.r = r; v.t = t; v.c = c; v.rd = rd; v.p = p; v.pe = pe; v.cn = cn; v.o = o;
    vecs.push_back(v);
  endfunction

  initial begin
    int base;
    int since;
    // reset hold, idle, single event, pop, ignored ready, clear vs pulse
    addv(0,0,0,0, 0,0,0,0);
    addv(0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 10; i++) addv(1,0,0,0, 0,0,0,0);
    addv(1,1,0,0, 0,0,0,0);
    addv(1,1,0,0, 0,0,0,0);
    addv(1,1,0,0, 1,0,0,0);
    addv(1,1,0,0, 0,1,1,0);
    addv(1,1,0,1, 0,0,1,0);
    addv(1,1,0,1, 0,0,1,0);
    addv(1,0,0,0, 0,0,1,0);
    addv(1,0,0,0, 0,0,1,0);
    addv(1,0,0,0, 1,0,1,0);
    addv(1,0,1,0, 0,1,0,0);
    addv(1,0,0,0, 0,1,0,0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; tog_in = vecs[i].t; clr_cnt = vecs[i].c; evt_ready = vecs[i].rd;
      step();
      chk($sformatf("vec%0d_pulse", i), int'(evt_pulse), vecs[i].p);
      chk($sformatf("vec%0d_pending", i), int'(pending), vecs[i].pe);
      chk($sformatf("vec%0d_valid", i), int'(evt_valid), (vecs[i].pe != 0) ? 1 : 0);
      chk($sformatf("vec%0d_count", i), int'(evt_count), vecs[i].cn);
      chk($sformatf("vec%0d_overflow", i), int'(overflow), vecs[i].o);
    end
    clr_cnt = 1'b0;

    // five spaced changes, nothing consumed
    do_reset();
    base = npulse;
    toggles(5, 3);
    repeat (4) step();
    chk("alt5_pulses", npulse - base, 5);
    chk("alt5_pending", int'(pending), 5);
    chk("alt5_count", int'(evt_count), 5);

    // saturation of pending and sticky overflow
    do_reset();
    toggles(7, 3);
    repeat (4) step();
    chk("ovf7_pending", int'(pending), 7);
    chk("ovf7_overflow", int'(overflow), 0);
    toggles(2, 3);
    repeat (4) step();
    chk("ovf9_pending", int'(pending), 7);
    chk("ovf9_overflow", int'(overflow), 1);
    chk("ovf9_count", int'(evt_count), 9);

    // pulse and pop together while full
    do_reset();
    toggles(7, 3);
    repeat (4) step();
    tog_in = ~tog_in;
    wait_pulse();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    step();
    chk("sim_pending", int'(pending), 7);
    chk("sim_overflow", int'(overflow), 0);
    chk("sim_count", int'(evt_count), 8);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    step();
    chk("pop_pending", int'(pending), 6);
    tog_in = ~tog_in;
    wait_pulse();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_count", int'(evt_count), 0);
    chk("clr_pending", int'(pending), 7);
    chk("clr_overflow", int'(overflow), 0);

    // counter wrap, then reset with events pending
    do_reset();
    evt_ready = 1'b1;
    base = npulse;
    toggles(256, 3);
    repeat (4) step();
    chk("wrap_pulses", npulse - base, 256);
    chk("wrap_count", int'(evt_count), 0);
    evt_ready = 1'b0;
    toggles(3, 3);
    repeat (4) step();
    chk("mid_pending_pre", int'(pending), 3);
    rst = 1'b0;
    step();
    chk("mid_pending", int'(pending), 0);
    chk("mid_valid", int'(evt_valid), 0);
    chk("mid_overflow", int'(overflow), 0);
    chk("mid_count", int'(evt_count), 0);
    rst = 1'b1;

    // random traffic against the reference model
    do_reset();
    chk_model = 1;
    since = 0;
    for (int i = 0; i < 3000; i++) begin
      since++;
      if (since >= 2 && ($urandom % 3) == 0) begin
        tog_in = ~tog_in;
        since = 0;
      end
      evt_ready = (i < 1500) ? (($urandom % 4) == 0) : (($urandom % 2) == 0);
      clr_cnt   = (($urandom % 40) == 0);
      rst       = (($urandom % 300) != 0);
      step();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
